ttt_game_ctrl: RTL and testbench
================================

TTT_GAME_CTRL -- requirements
Module: ttt_game_ctrl

Interface
REQ-001 The block SHALL have the port: clk  input  1  single clock; all state updates on the rising edge.
REQ-002 The block SHALL have the port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 The block SHALL have the port: new_game  input  1  synchronous board clear and game restart, active-high.
REQ-004 The block SHALL have the port: move_valid  input  1  a move request is present.
REQ-005 The block SHALL have the port: move_row  input  2  target row 0..2; value 3 is illegal.
REQ-006 The block SHALL have the port: move_col  input  2  target column 0..2; value 3 is illegal.
REQ-007 The block SHALL have the port: move_ready  output  1  block accepts a move this cycle.
REQ-008 The block SHALL have the port: board  output  18  cell (r,c) at bits [2*(3r+c)+1 : 2*(3r+c)]; cell code 00 empty, 01 O, 10 X, 11 never produced.
REQ-009 The block SHALL have the port: turn  output  1  player to move; 0 O, 1 X.
REQ-010 The block SHALL have the port: illegal  output  1  one-cycle pulse; a move was rejected.
REQ-011 The block SHALL have the port: game_over  output  1  game has ended (win or draw).
REQ-012 The block SHALL have the port: winner  output  2  00 none or draw, 01 O won, 10 X won.
REQ-013 The block SHALL have the port: move_count  output  4  number of accepted moves, 0..9.

Function
REQ-014 The FSM SHALL have the states PLAY, CHECK, WIN and DRAW; move_ready SHALL be 1 only in PLAY.
REQ-015 A handshake SHALL occur when move_valid=1 and move_ready=1 on a rising edge; move_valid in other states SHALL be ignored with no illegal pulse.
REQ-016 A handshaked move SHALL be rejected if move_row=3, move_col=3, or the target cell is non-empty.
  - On rejection, illegal=1 for exactly the next cycle.
  - Board, turn and move_count SHALL be unchanged, and the state SHALL stay PLAY.
REQ-017 On a legal handshake, on that edge:
  - The target cell SHALL be written with the mover's code (turn=1 -> 10, turn=0 -> 01).
  - move_count SHALL increment by 1.
  - The state SHALL go to CHECK.
  - turn SHALL hold.
REQ-018 In CHECK, the block SHALL evaluate all 8 lines (3 rows, 3 columns, 2 diagonals) for three cells equal to the mover's code; the next edge SHALL select the next state:
  - Any line complete -> WIN, winner = mover's code, game_over=1.
  - Else move_count=9 -> DRAW, winner=00, game_over=1.
  - Else -> PLAY with turn toggled.
REQ-019 Latency: legal move accepted at edge N; board visible after edge N; game_over/winner/turn update visible after edge N+1; the next move can be accepted at edge N+2 at the earliest.
REQ-020 WIN and DRAW SHALL be absorbing; board, winner, turn and move_count SHALL hold until new_game or reset.
REQ-021 A win on the 9th move SHALL report WIN, not DRAW.
REQ-022 new_game=1 on an edge in any state SHALL, on that edge:
  - Clear board to all-zero, move_count to 0, winner to 00, game_over to 0 and illegal to 0.
  - Set turn to 1 (X first) and the state to PLAY.
REQ-023 new_game SHALL take priority over a simultaneous move_valid; that move SHALL be dropped without an illegal pulse.
REQ-024 new_game asserted while in CHECK SHALL abort the evaluation; no win or draw SHALL be reported for the aborted move.

Reset
REQ-025 rst_n=0 on a rising edge SHALL produce the same register values as new_game: board=0, turn=1, move_count=0, winner=00, game_over=0, illegal=0, state PLAY, so move_ready=1 after the edge.
REQ-026 rst_n SHALL take priority over new_game and move_valid.
REQ-027 Reset mid-game, including in CHECK, SHALL discard all state with no residual pulse.
REQ-028 Outputs SHALL be undefined only before the first reset edge.

Verification
REQ-029 Scenario (row win): after reset, moves X(0,0), O(1,0), X(0,1), O(1,1), X(0,2) -> two cycles after the 5th accept: game_over=1, winner=10, move_count=5, move_ready=0.
REQ-030 Scenario (illegal moves): after X(1,1), O tries (1,1), then (3,0) -> illegal pulses one cycle each; board[9:8]=10; turn stays 0; move_count=1.
REQ-031 Scenario (draw): X(0,0) O(0,1) X(0,2) O(1,1) X(1,0) O(1,2) X(2,1) O(2,0) X(2,2) -> board=18'b10_10_01_01_01_10_10_01_10 (cell 8 down to 0), winner=00, game_over=1, move_count=9.
REQ-032 Scenario (diagonal win on 9th move): 9th move completes a diagonal -> winner set to mover's code, not DRAW.
REQ-033 Scenario (new_game with move): new_game and move_valid asserted together in PLAY -> board=0, turn=1, move_count=0, no illegal pulse; new_game in CHECK after a winning move -> game_over stays 0.
REQ-034 Scenario (reset priority): rst_n=0 with new_game=1 and move_valid=1 in WIN -> all outputs at reset values after the edge, and move_ready=1.

Source files
------------

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: accepts moves, rejects illegal ones, and
// checks for a win or draw in a separate cycle after each legal move.
module ttt_game_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        new_game,
    input  logic        move_valid,
    input  logic [1:0]  move_row,
    input  logic [1:0]  move_col,
    output logic        move_ready,
    output logic [17:0] board,
    output logic        turn,
    output logic        illegal,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [3:0]  move_count
);

    // Handshake: a move is taken on a rising edge where move_valid=1 and
    // move_ready=1; move_ready is high only in PLAY, so requests are ignored
    // while a move is being evaluated or after the game has ended.
    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        WIN   = 2'd2,
        DRAW  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [17:0] board_q, board_d;
    logic        turn_q, turn_d;
    logic        illegal_q, illegal_d;
    logic [1:0]  winner_q, winner_d;
    logic [3:0]  move_count_q, move_count_d;

    logic [1:0]  mover_code;
    logic [3:0]  cell_idx;
    logic [1:0]  cell_val;
    logic        off_board;
    logic [8:0]  mine;
    logic        line_done;

    assign mover_code = turn_q ? 2'b10 : 2'b01;

    // cell_idx aliases a real cell for row/col 3; off_board masks that case.
    always_comb begin
        cell_idx  = ({2'b00, move_row} * 4'd3) + {2'b00, move_col};
        off_board = (move_row == 2'd3) || (move_col == 2'd3);
        cell_val  = 2'b00;
        mine      = '0;
        for (int i = 0; i < 9; i++) begin
            if (cell_idx == 4'(i)) begin
                cell_val = board_q[2*i +: 2];
            end
            mine[i] = (board_q[2*i +: 2] == mover_code);
        end
        line_done = (mine[0] & mine[1] & mine[2]) |
                    (mine[3] & mine[4] & mine[5]) |
                    (mine[6] & mine[7] & mine[8]) |
                    (mine[0] & mine[3] & mine[6]) |
                    (mine[1] & mine[4] & mine[7]) |
                    (mine[2] & mine[5] & mine[8]) |
                    (mine[0] & mine[4] & mine[8]) |
                    (mine[2] & mine[4] & mine[6]);
    end

    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        turn_d       = turn_q;
        illegal_d    = 1'b0;
        winner_d     = winner_q;
        move_count_d = move_count_q;

        if (new_game) begin
            state_d      = PLAY;
            board_d      = '0;
            turn_d       = 1'b1;
            winner_d     = 2'b00;
            move_count_d = 4'd0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (move_valid) begin
                        if (off_board || (cell_val != 2'b00)) begin
                            illegal_d = 1'b1;
                        end else begin
                            for (int i = 0; i < 9; i++) begin
                                if (cell_idx == 4'(i)) begin
                                    board_d[2*i +: 2] = mover_code;
                                end
                            end
                            move_count_d = move_count_q + 4'd1;
                            state_d      = CHECK;
                        end
                    end
                end
                // A win is tested before the full-board draw so a winning
                // ninth move is reported as a win.
                CHECK: begin
                    if (line_done) begin
                        state_d  = WIN;
                        winner_d = mover_code;
                    end else if (move_count_q == 4'd9) begin
                        state_d  = DRAW;
                        winner_d = 2'b00;
                    end else begin
                        state_d = PLAY;
                        turn_d  = ~turn_q;
                    end
                end
                WIN, DRAW: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = PLAY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= PLAY;
            board_q      <= '0;
            turn_q       <= 1'b1;
            illegal_q    <= 1'b0;
            winner_q     <= 2'b00;
            move_count_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            turn_q       <= turn_d;
            illegal_q    <= illegal_d;
            winner_q     <= winner_d;
            move_count_q <= move_count_d;
        end
    end

    assign move_ready = (state_q == PLAY);
    assign game_over  = (state_q == WIN) || (state_q == DRAW);
    assign board      = board_q;
    assign turn       = turn_q;
    assign illegal    = illegal_q;
    assign winner     = winner_q;
    assign move_count = move_count_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl: the driver pushes hand-computed output
// snapshots into a queue and a negedge monitor pops and compares them.
module tb_ttt_game_ctrl;

    logic        clk;
    logic        rst_n;
    logic        new_game;
    logic        move_valid;
    logic [1:0]  move_row;
    logic [1:0]  move_col;
    logic        move_ready;
    logic [17:0] board;
    logic        turn;
    logic        illegal;
    logic        game_over;
    logic [1:0]  winner;
    logic [3:0]  move_count;

    ttt_game_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .new_game   (new_game),
        .move_valid (move_valid),
        .move_row   (move_row),
        .move_col   (move_col),
        .move_ready (move_ready),
        .board      (board),
        .turn       (turn),
        .illegal    (illegal),
        .game_over  (game_over),
        .winner     (winner),
        .move_count (move_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // scoreboard: {board, turn, illegal, game_over, winner, move_count, move_ready}
    logic [27:0] exp_q[$];
    string       name_q[$];
    int          checks     = 0;
    int          failures   = 0;
    int          ill_seen   = 0;

    localparam logic [17:0] B_ROWWIN = 18'b00_00_00_00_01_01_10_10_10;
    localparam logic [17:0] B_CENTER = 18'b00_00_00_00_10_00_00_00_00;
    localparam logic [17:0] B_DRAW   = 18'b10_10_01_01_01_10_10_01_10;
    localparam logic [17:0] B_DIAG   = 18'b10_01_10_01_10_01_01_10_10;

    task automatic check(input string nm, input string fld,
                         input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s got=%h exp=%h", nm, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [27:0] e;
        string       nm;
        if (illegal === 1'b1) ill_seen++;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check(nm, "board",      board,             e[27:10]);
            check(nm, "turn",       18'(turn),         18'(e[9]));
            check(nm, "illegal",    18'(illegal),      18'(e[8]));
            check(nm, "game_over",  18'(game_over),    18'(e[7]));
            check(nm, "winner",     18'(winner),       18'(e[6:5]));
            check(nm, "move_count", 18'(move_count),   18'(e[4:1]));
            check(nm, "move_ready", 18'(move_ready),   18'(e[0]));
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_snap(input string nm, input logic [17:0] b, input logic t,
                               input logic il, input logic go, input logic [1:0] w,
                               input logic [3:0] mc, input logic mr);
        exp_q.push_back({b, t, il, go, w, mc, mr});
        name_q.push_back(nm);
    endtask

    task automatic expect_reset(input string nm);
        expect_snap(nm, 18'd0, 1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 1'b1);
    endtask

    // Leaves move_valid high so the following edge also sees a request.
    task automatic accept(input logic [1:0] r, input logic [1:0] c);
        move_valid = 1'b1;
        move_row   = r;
        move_col   = c;
        step();
    endtask

    // CHECK edge with the just-played (now occupied) request still asserted.
    task automatic settle();
        step();
        move_valid = 1'b0;
    endtask

    task automatic mv(input logic [1:0] r, input logic [1:0] c);
        accept(r, c);
        settle();
    endtask

    task automatic idle();
        move_valid = 1'b0;
        step();
    endtask

    task automatic new_game_pulse();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        new_game   = 1'b0;
        move_valid = 1'b0;
        move_row   = 2'd0;
        move_col   = 2'd0;
        step();
        step();
        expect_reset("reset");
        rst_n = 1'b1;

        // row win by X on the top row
        accept(2'd0, 2'd0);
        expect_snap("a_m1_acc", 18'd2, 1'b1, 1'b0, 1'b0, 2'b00, 4'd1, 1'b0);
        settle();
        expect_snap("a_m1_chk", 18'd2, 1'b0, 1'b0, 1'b0, 2'b00, 4'd1, 1'b1);
        mv(2'd1, 2'd0);
        mv(2'd0, 2'd1);
        mv(2'd1, 2'd1);
        accept(2'd0, 2'd2);
        expect_snap("a_m5_acc", B_ROWWIN, 1'b1, 1'b0, 1'b0, 2'b00, 4'd5, 1'b0);
        settle();
        expect_snap("a_win", B_ROWWIN, 1'b1, 1'b0, 1'b1, 2'b10, 4'd5, 1'b0);
        accept(2'd2, 2'd2);
        expect_snap("a_hold", B_ROWWIN, 1'b1, 1'b0, 1'b1, 2'b10, 4'd5, 1'b0);
        idle();
        expect_snap("a_hold2", B_ROWWIN, 1'b1, 1'b0, 1'b1, 2'b10, 4'd5, 1'b0);

        // illegal moves: occupied cell, row 3, column 3
        new_game_pulse();
        expect_reset("b_newgame");
        mv(2'd1, 2'd1);
        expect_snap("b_x11", B_CENTER, 1'b0, 1'b0, 1'b0, 2'b00, 4'd1, 1'b1);
        accept(2'd1, 2'd1);
        expect_snap("b_ill_occ", B_CENTER, 1'b0, 1'b1, 1'b0, 2'b00, 4'd1, 1'b1);
        idle();
        expect_snap("b_ill_clr", B_CENTER, 1'b0, 1'b0, 1'b0, 2'b00, 4'd1, 1'b1);
        accept(2'd3, 2'd0);
        expect_snap("b_ill_row", B_CENTER, 1'b0, 1'b1, 1'b0, 2'b00, 4'd1, 1'b1);
        idle();
        expect_snap("b_ill_clr2", B_CENTER, 1'b0, 1'b0, 1'b0, 2'b00, 4'd1, 1'b1);
        accept(2'd0, 2'd3);
        expect_snap("b_ill_col", B_CENTER, 1'b0, 1'b1, 1'b0, 2'b00, 4'd1, 1'b1);
        idle();
        mv(2'd0, 2'd0);
        expect_snap("b_legal", B_CENTER | 18'd1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd2, 1'b1);

        // full-board draw
        new_game_pulse();
        mv(2'd0, 2'd0); mv(2'd0, 2'd1); mv(2'd0, 2'd2); mv(2'd1, 2'd1);
        mv(2'd1, 2'd0); mv(2'd1, 2'd2); mv(2'd2, 2'd1); mv(2'd2, 2'd0);
        accept(2'd2, 2'd2);
        expect_snap("c_m9_acc", B_DRAW, 1'b1, 1'b0, 1'b0, 2'b00, 4'd9, 1'b0);
        settle();
        expect_snap("c_draw", B_DRAW, 1'b1, 1'b0, 1'b1, 2'b00, 4'd9, 1'b0);

        // diagonal win on the ninth move
        new_game_pulse();
        mv(2'd0, 2'd0); mv(2'd0, 2'd2); mv(2'd1, 2'd1); mv(2'd1, 2'd0);
        mv(2'd0, 2'd1); mv(2'd2, 2'd1); mv(2'd2, 2'd0); mv(2'd1, 2'd2);
        mv(2'd2, 2'd2);
        expect_snap("d_diag9", B_DIAG, 1'b1, 1'b0, 1'b1, 2'b10, 4'd9, 1'b0);

        // new_game with a simultaneous move, and new_game during CHECK
        new_game_pulse();
        mv(2'd0, 2'd0);
        new_game   = 1'b1;
        move_valid = 1'b1;
        move_row   = 2'd1;
        move_col   = 2'd1;
        step();
        new_game   = 1'b0;
        move_valid = 1'b0;
        expect_reset("e_ng_mv");
        step();
        expect_reset("e_ng_mv2");
        mv(2'd0, 2'd0); mv(2'd1, 2'd0); mv(2'd0, 2'd1); mv(2'd1, 2'd1);
        accept(2'd0, 2'd2);
        move_valid = 1'b0;
        new_game   = 1'b1;
        step();
        new_game   = 1'b0;
        expect_reset("e_ng_chk");
        step();
        expect_reset("e_ng_chk2");

        // reset during CHECK
        accept(2'd0, 2'd0);
        rst_n = 1'b0;
        step();
        rst_n      = 1'b1;
        move_valid = 1'b0;
        expect_reset("f_rst_chk");
        step();
        expect_reset("f_rst_chk2");

        // reset beats new_game and move_valid while in WIN
        mv(2'd0, 2'd0); mv(2'd1, 2'd0); mv(2'd0, 2'd1); mv(2'd1, 2'd1);
        mv(2'd0, 2'd2);
        expect_snap("f_pre_win", B_ROWWIN, 1'b1, 1'b0, 1'b1, 2'b10, 4'd5, 1'b0);
        rst_n      = 1'b0;
        new_game   = 1'b1;
        move_valid = 1'b1;
        move_row   = 2'd2;
        move_col   = 2'd2;
        step();
        rst_n      = 1'b1;
        new_game   = 1'b0;
        move_valid = 1'b0;
        expect_reset("f_rst_win");
        step();
        expect_reset("f_rst_win2");

        repeat (2) @(negedge clk);
        check("end", "illegal_cycles", 18'(ill_seen), 18'd3);
        check("end", "queue_left", 18'(exp_q.size()), 18'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
